mem_bank_pwr_seq: RTL and testbench

// - Sequences the power switches of NUM_BANKS memory banks, one bank at a time, with staggered turn-on to limit inrush.
// - Drives each bank's switch control (VCTRL) and checks the switch-chain feedback (VCTRL_BUF) against a timeout.
// - Controls per-bank isolation. Sits between the power manager's per-bank on/off requests and the switch cells in each bank.

---
 rtl/mem_pwr_pkg.sv | 19 +
 rtl/mem_pwr_sync2.sv | 21 ++
 rtl/mem_pwr_timer.sv | 23 ++
 rtl/mem_bank_pwr_seq.sv | 157 +++++++++++++++
 tb/tb_mem_bank_pwr_seq.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pwr_pkg.sv
// Shared types and helpers for the memory bank power sequencer.
package mem_pwr_pkg;

   localparam int MAX_BANKS = 32;

   typedef enum logic [2:0] {
      IDLE,
      ISO_ON,
      SWITCH,
      WAIT_ACK,
      SETTLE,
      ISO_OFF
   } pwr_state_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mem_pwr_sync2.sv
// Two-flop synchroniser cell for one asynchronous bit.
module mem_pwr_sync2 (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= 1'b0;
         q_o  <= 1'b0;
      end else begin
         s1_q <= d_i;
         q_o  <= s1_q;
      end
   end

endmodule

// File: rtl/mem_pwr_timer.sv
// Shared cycle counter: clear, enable, and compare against a terminal count.
module mem_pwr_timer #(
   parameter int CNT_W = 7
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] term_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)     cnt_q <= '0;
      else if (clr_i)  cnt_q <= '0;
      else if (en_i)   cnt_q <= cnt_q + 1'b1;
   end

   assign done_o = (cnt_q == term_i);

endmodule

// File: rtl/mem_bank_pwr_seq.sv
// Serialises per-bank power switch on/off sequences with isolation control,
// ack timeout fault tracking and a settle gap between banks.
module mem_bank_pwr_seq
   import mem_pwr_pkg::*;
#(
   parameter int NUM_BANKS      = 4,
   parameter int STAGGER_CYCLES = 8,
   parameter int ACK_TIMEOUT    = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NUM_BANKS-1:0] bank_on_req_i,
   output logic [NUM_BANKS-1:0] switch_ctrl_o,
   input  logic [NUM_BANKS-1:0] switch_ack_i,
   output logic [NUM_BANKS-1:0] iso_o,
   output logic [NUM_BANKS-1:0] bank_pwr_ok_o,
   output logic [NUM_BANKS-1:0] bank_fault_o,
   input  logic                 clr_fault_i,
   output logic                 busy_o
);

   localparam int CNT_W = $clog2(max2(STAGGER_CYCLES, ACK_TIMEOUT) + 1);
   localparam int KW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam logic [CNT_W-1:0] ACK_TERM    = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(STAGGER_CYCLES - 1);

   pwr_state_e state_q, state_d;
   logic [KW-1:0] k_q, sel, idx;
   logic up_q, up, any_pend, ack_ok;
   logic [NUM_BANKS-1:0] pend, ack_sync;
   logic t_clr, t_en, t_done;
   logic [CNT_W-1:0] t_term;
   logic do_sw, do_iso_on, do_iso_off, do_fault;

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_sync
      mem_pwr_sync2 u_sync (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .d_i    (switch_ack_i[g]),
         .q_o    (ack_sync[g])
      );
   end

   mem_pwr_timer #(.CNT_W(CNT_W)) u_timer (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (t_clr),
      .en_i   (t_en),
      .term_i (t_term),
      .done_o (t_done)
   );

   assign t_term = (state_q == SETTLE) ? SETTLE_TERM : ACK_TERM;

   // Lowest-index pending bank wins; loop runs high to low so the last hit sticks.
   always_comb begin
      pend = (bank_on_req_i ^ bank_pwr_ok_o) & ~bank_fault_o;
      any_pend = |pend;
      sel = '0;
      for (int i = NUM_BANKS - 1; i >= 0; i--) begin
         if (pend[i]) sel = KW'(i);
      end
   end

   // In IDLE the bank being launched is the fresh selection, not yet latched.
   assign idx    = (state_q == IDLE) ? sel : k_q;
   assign up     = (state_q == IDLE) ? bank_on_req_i[sel] : up_q;
   assign ack_ok = (ack_sync[k_q] == switch_ctrl_o[k_q]);

   always_comb begin
      state_d    = state_q;
      t_clr      = 1'b0;
      t_en       = 1'b0;
      do_sw      = 1'b0;
      do_iso_on  = 1'b0;
      do_iso_off = 1'b0;
      do_fault   = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_pend) begin
               if (up) begin
                  state_d = SWITCH;
                  do_sw   = 1'b1;
               end else begin
                  state_d   = ISO_ON;
                  do_iso_on = 1'b1;
               end
            end
         end
         ISO_ON: begin
            state_d = SWITCH;
            do_sw   = 1'b1;
         end
         SWITCH: begin
            state_d = WAIT_ACK;
            t_clr   = 1'b1;
         end
         WAIT_ACK: begin
            if (ack_ok) begin
               state_d = SETTLE;
               t_clr   = 1'b1;
            end else if (t_done) begin
               state_d  = IDLE;
               do_fault = 1'b1;
            end else begin
               t_en = 1'b1;
            end
         end
         SETTLE: begin
            if (t_done) begin
               if (up_q) begin
                  state_d    = ISO_OFF;
                  do_iso_off = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               t_en = 1'b1;
            end
         end
         ISO_OFF: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         k_q           <= '0;
         up_q          <= 1'b0;
         switch_ctrl_o <= '1;
         iso_o         <= '1;
         bank_pwr_ok_o <= '0;
         bank_fault_o  <= '0;
         busy_o        <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_o  <= (state_d != IDLE);
         if (state_q == IDLE) begin
            k_q  <= sel;
            up_q <= bank_on_req_i[sel];
         end
         if (do_sw) switch_ctrl_o[idx] <= ~up;
         if (do_iso_on) begin
            iso_o[idx]         <= 1'b1;
            bank_pwr_ok_o[idx] <= 1'b0;
         end
         if (do_iso_off) begin
            iso_o[idx]         <= 1'b0;
            bank_pwr_ok_o[idx] <= 1'b1;
         end
         if (clr_fault_i)   bank_fault_o      <= '0;
         else if (do_fault) bank_fault_o[idx] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_bank_pwr_seq.sv
// Directed bench for mem_bank_pwr_seq; the switch chain is modelled as a
// 3-cycle delay from switch_ctrl_o back to switch_ack_i, with per-bank stuck override.
module tb_mem_bank_pwr_seq;

   localparam int STAGGER = 8;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic [3:0] bank_on_req_i = 4'b0000;
   logic [3:0] switch_ack_i;
   logic       clr_fault_i = 1'b0;
   logic [3:0] switch_ctrl_o, iso_o, bank_pwr_ok_o, bank_fault_o;
   logic       busy_o;

   logic [3:0] p1 = 4'hF, p2 = 4'hF, p3 = 4'hF;
   logic [3:0] stuck_en = 4'b0000, stuck_val = 4'b0000;

   int n_tests = 0;
   int n_fail  = 0;
   int fall [4];
   int cyc;
   logic [3:0] prev;
   logic found;

   mem_bank_pwr_seq #(
      .NUM_BANKS(4), .STAGGER_CYCLES(STAGGER), .ACK_TIMEOUT(64)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .bank_on_req_i (bank_on_req_i),
      .switch_ctrl_o (switch_ctrl_o),
      .switch_ack_i  (switch_ack_i),
      .iso_o         (iso_o),
      .bank_pwr_ok_o (bank_pwr_ok_o),
      .bank_fault_o  (bank_fault_o),
      .clr_fault_i   (clr_fault_i),
      .busy_o        (busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      p1 <= switch_ctrl_o;
      p2 <= p1;
      p3 <= p2;
   end
   assign switch_ack_i = (p3 & ~stuck_en) | (stuck_val & stuck_en);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      bank_on_req_i = 4'b0000;
      clr_fault_i = 1'b0;
      tick(2);
      rst_ni = 1'b1;
      tick(3);
   endtask

   task automatic wait_idle(input string tag, input logic [3:0] exp_ok, input int maxc);
      for (int c = 0; c < maxc; c++) begin
         tick(1);
         if (!busy_o && bank_pwr_ok_o == exp_ok) break;
      end
      check(tag, {busy_o, bank_pwr_ok_o}, {1'b0, exp_ok});
   endtask

   task automatic wait_ctrl_low(input string tag, input int b, input int maxc);
      found = 1'b0;
      for (int c = 0; c < maxc; c++) begin
         tick(1);
         if (switch_ctrl_o[b] == 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      check(tag, found, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      tick(1);
      check("rst_ctrl", switch_ctrl_o, 4'hF);
      check("rst_iso", iso_o, 4'hF);
      check("rst_ok", bank_pwr_ok_o, 4'h0);
      check("rst_fault", bank_fault_o, 4'h0);
      check("rst_busy", busy_o, 1'b0);
      rst_ni = 1'b1;
      tick(3);

      // Single bank power-up with exact timing
      bank_on_req_i = 4'b0001;
      tick(1);
      check("t1_ctrl", switch_ctrl_o, 4'b1110);
      check("t1_busy", busy_o, 1'b1);
      check("t1_iso_held", iso_o, 4'hF);
      tick(13);
      check("t1_ok_early", bank_pwr_ok_o, 4'h0);
      tick(1);
      check("t1_ok", bank_pwr_ok_o, 4'b0001);
      check("t1_iso", iso_o, 4'b1110);
      check("t1_busy_isooff", busy_o, 1'b1);
      tick(1);
      check("t1_busy_done", busy_o, 1'b0);

      // All banks from off: ordered, staggered
      do_reset();
      for (int b = 0; b < 4; b++) fall[b] = -1;
      prev = switch_ctrl_o;
      cyc = 0;
      bank_on_req_i = 4'b1111;
      for (int c = 0; c < 150; c++) begin
         tick(1);
         cyc++;
         for (int b = 0; b < 4; b++)
            if (prev[b] && !switch_ctrl_o[b]) fall[b] = cyc;
         prev = switch_ctrl_o;
         if (!busy_o && bank_pwr_ok_o == 4'hF) break;
      end
      check("t2_ok", {busy_o, bank_pwr_ok_o}, 5'h0F);
      check("t2_iso", iso_o, 4'h0);
      check("t2_fall0", fall[0], 1);
      for (int b = 0; b < 3; b++)
         check($sformatf("t2_gap%0d", b), (fall[b+1] - fall[b] >= STAGGER + 4), 1'b1);

      // Power-down bank 2: isolation leads the switch by one cycle
      bank_on_req_i = 4'b1011;
      tick(1);
      check("t3_iso", iso_o, 4'b0100);
      check("t3_ok", bank_pwr_ok_o, 4'b1011);
      check("t3_ctrl_held", switch_ctrl_o, 4'b0000);
      tick(1);
      check("t3_ctrl", switch_ctrl_o, 4'b0100);
      wait_idle("t3_done", 4'b1011, 100);
      check("t3_iso_final", iso_o, 4'b0100);

      // Bank 1 ack stuck high: timeout, fault, skip, then clear and retry
      do_reset();
      stuck_en = 4'b0010;
      stuck_val = 4'b0010;
      bank_on_req_i = 4'b0111;
      wait_ctrl_low("t4_b1_start", 1, 100);
      tick(64);
      check("t4_fault_early", bank_fault_o, 4'b0000);
      tick(1);
      check("t4_fault", bank_fault_o, 4'b0010);
      check("t4_busy_idle", busy_o, 1'b0);
      wait_idle("t4_skip", 4'b0101, 100);
      check("t4_ctrl", switch_ctrl_o, 4'b1000);
      check("t4_iso", iso_o, 4'b1010);
      tick(5);
      check("t4_no_retry", {busy_o, bank_fault_o}, 5'b0_0010);
      stuck_en = 4'b0000;
      clr_fault_i = 1'b1;
      tick(1);
      clr_fault_i = 1'b0;
      check("t4_clr", bank_fault_o, 4'b0000);
      wait_idle("t4_retry", 4'b0111, 100);

      // Reset during WAIT_ACK of bank 3, then restart from IDLE
      bank_on_req_i = 4'b1111;
      wait_ctrl_low("t5_b3_start", 3, 100);
      tick(2);
      #2 rst_ni = 1'b0;
      #1;
      check("t5_rst_ctrl", switch_ctrl_o, 4'hF);
      check("t5_rst_iso", iso_o, 4'hF);
      check("t5_rst_ok", bank_pwr_ok_o, 4'h0);
      check("t5_rst_busy", busy_o, 1'b0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick(1);
      check("t5_restart", {busy_o, switch_ctrl_o}, 5'b1_1110);
      wait_idle("t5_done", 4'hF, 250);

      // Request withdrawn during SETTLE: completes up, then powers down
      do_reset();
      bank_on_req_i = 4'b0001;
      tick(8);
      bank_on_req_i = 4'b0000;
      tick(7);
      check("t6_up_done", bank_pwr_ok_o, 4'b0001);
      check("t6_iso_off", iso_o, 4'b1110);
      tick(2);
      check("t6_iso_on", iso_o, 4'hF);
      check("t6_ok_drop", {busy_o, bank_pwr_ok_o}, 5'b1_0000);
      wait_idle("t6_down", 4'b0000, 100);
      check("t6_ctrl", switch_ctrl_o, 4'hF);

      // clr_fault_i in the same cycle as a timeout wins
      do_reset();
      stuck_en = 4'b0001;
      stuck_val = 4'b0001;
      bank_on_req_i = 4'b0001;
      tick(1);
      check("t7_ctrl", switch_ctrl_o, 4'b1110);
      tick(64);
      check("t7_fault_early", bank_fault_o, 4'b0000);
      check("t7_busy_wait", busy_o, 1'b1);
      clr_fault_i = 1'b1;
      bank_on_req_i = 4'b0000;
      tick(1);
      clr_fault_i = 1'b0;
      check("t7_clr_prio", {busy_o, bank_fault_o}, 5'b0_0000);
      tick(3);
      check("t7_hold", {busy_o, switch_ctrl_o, iso_o}, 9'b0_1110_1111);
      stuck_en = 4'b0000;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
